navre_regress_io: RTL

Parametrised IO-space responder for the navre core regression environment. Sits on the core's IO bus (`io_re`/`io_we`/`io_a`/`io_do`/`io_di`) in place of a plain address-echo model and provides:
- scratch registers;
- a buffered console output stream with a valid/ready drain port;
- a snapshot cycle counter;
- a sticky test-result register.

It lets regression programs report progress and pass/fail status without testbench-side `$display` decoding.

---
 rtl/navre_regress_io_if.sv | 12 +
 rtl/navre_regress_io.sv | 126 ++++++++++++
 2 files changed

// File: rtl/navre_regress_io_if.sv
// IO bus between the navre core and an IO-space responder.
// The core is the master: it drives the strobes, address and write data, and receives read data.
interface navre_regress_io_if;
  logic       io_re;
  logic       io_we;
  logic [5:0] io_a;
  logic [7:0] io_do;
  logic [7:0] io_di;

  modport master (output io_re, io_we, io_a, io_do, input io_di);
  modport slave  (input io_re, io_we, io_a, io_do, output io_di);
endinterface

// File: rtl/navre_regress_io.sv
// IO-space responder for navre regressions: scratch registers, console FIFO,
// snapshot cycle counter and a sticky test-result register.
module navre_regress_io #(
  parameter int unsigned nscratch  = 8,
  parameter int unsigned fifo_aw   = 4,
  parameter int unsigned cyc_width = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  navre_regress_io_if.slave        io,
  output logic [7:0]               cons_data,
  output logic                     cons_valid,
  input  logic                     cons_ready,
  output logic                     done,
  output logic [7:0]               result
);

  localparam int unsigned depth = 1 << fifo_aw;

  localparam logic [5:0] a_cons_data = 6'h30;
  localparam logic [5:0] a_cons_stat = 6'h31;
  localparam logic [5:0] a_cyc_lo    = 6'h32;
  localparam logic [5:0] a_cyc_hi    = 6'h33;
  localparam logic [5:0] a_result    = 6'h3E;
  localparam logic [5:0] a_id        = 6'h3F;

  logic [7:0]           scratch [nscratch];
  logic [7:0]           fifo_mem [depth];
  logic [fifo_aw-1:0]   wr_ptr, rd_ptr;
  logic [fifo_aw:0]     count;
  logic                 overflow;
  logic [cyc_width-1:0] cyc, snap;

  logic       push_req, push, pop, full, empty, ovf_set, stat_rd, cyc_lo_rd;
  logic [7:0] rdata;

  // count never exceeds depth, so its top bit alone marks a full FIFO
  assign full       = count[fifo_aw];
  assign empty      = (count == '0);
  assign cons_valid = !empty;
  assign cons_data  = fifo_mem[rd_ptr];

  assign pop       = cons_valid && cons_ready;
  assign push_req  = io.io_we && (io.io_a == a_cons_data);
  // A pop in the same cycle frees the slot the push lands in
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign stat_rd   = io.io_re && (io.io_a == a_cons_stat);
  assign cyc_lo_rd = io.io_re && (io.io_a == a_cyc_lo);

  // Read data reflects pre-write state; only a coincident overflow is folded in
  always_comb begin
    rdata = {2'b00, io.io_a};
    case (io.io_a)
      a_cons_data: rdata = 8'(count);
      a_cons_stat: rdata = {5'b0, overflow | ovf_set, empty, full};
      a_cyc_lo:    rdata = cyc[7:0];
      a_cyc_hi:    rdata = 8'(snap >> 8);
      a_result:    rdata = result;
      a_id:        rdata = 8'hA5;
      default: begin
        for (int i = 0; i < nscratch; i++) begin
          if (io.io_a == 6'(i)) rdata = scratch[i];
        end
      end
    endcase
  end

  // NOTE: scratch is a small register file that must read zero after reset, so
  // every entry is reset explicitly; the FIFO storage below is deliberately not.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      io.io_di <= '0;
      for (int i = 0; i < nscratch; i++) scratch[i] <= '0;
    end else begin
      if (io.io_re) io.io_di <= rdata;
      if (io.io_we) begin
        for (int i = 0; i < nscratch; i++) begin
          if (io.io_a == 6'(i)) scratch[i] <= io.io_do;
        end
      end
    end
  end

  // Contents are only observable through valid pointers/count, which are reset
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr] <= io.io_do;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + fifo_aw'(1);
      if (pop)  rd_ptr <= rd_ptr + fifo_aw'(1);
      case ({push, pop})
        2'b10:   count <= count + (fifo_aw + 1)'(1);
        2'b01:   count <= count - (fifo_aw + 1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
    end
  end

  // The counter still advances on the edge that sets done, then freezes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc    <= '0;
      snap   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      if (!done)     cyc  <= cyc + cyc_width'(1);
      if (cyc_lo_rd) snap <= cyc;
      if (io.io_we && (io.io_a == a_result) && !done) begin
        done   <= 1'b1;
        result <= io.io_do;
      end
    end
  end

endmodule
